// File: rtl/ezrisc_pkg.sv
// Shared ezrisc definitions: ALU control codes and the writeback FSM encoding.
package ezrisc_pkg;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9,
        AluMul  = 4'd10,
        AluMulu = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWrLo = 2'd1,
        StWrHi = 2'd2
    } wb_state_e;

endpackage

// File: rtl/alu_writeback.sv
// ALU result writeback: splits a 2*DATA_W result into one or two register-file writes
// and keeps the most recent wide upper half in hi_out.
module alu_writeback
    import ezrisc_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   in_result,
    input  logic                  in_wide,
    input  logic [RADDR_W-1:0]    in_rd,
    output logic                  rf_we,
    output logic [RADDR_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [DATA_W-1:0]     hi_out,
    output logic                  busy
);

    localparam logic [RADDR_W-1:0] RdOne = RADDR_W'(1);

    wb_state_e             state_q, state_d;
    logic [2*DATA_W-1:0]   result_q;
    logic                  wide_q;
    logic [RADDR_W-1:0]    rd_q;
    logic [DATA_W-1:0]     hi_q;
    logic                  accept;

    // Ready depends only on state and the latched width, never on in_valid.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle:  in_ready = 1'b1;
                StWrLo:  in_ready = !wide_q;
                StWrHi:  in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = accept ? StWrLo : StIdle;
            StWrLo:  state_d = wide_q ? StWrHi : (accept ? StWrLo : StIdle);
            StWrHi:  state_d = accept ? StWrLo : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rf_waddr = '0;
        rf_wdata = '0;
        unique case (state_q)
            StWrLo: begin
                rf_waddr = rd_q;
                rf_wdata = result_q[DATA_W-1:0];
            end
            StWrHi: begin
                rf_waddr = rd_q + RdOne;
                rf_wdata = result_q[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
        // x0 is hardwired; also suppresses the rd=31 wide wrap onto x0.
        rf_we = (state_q != StIdle) && (rf_waddr != '0);
    end

    assign busy   = (state_q != StIdle);
    assign hi_out = hi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            result_q <= '0;
            wide_q   <= 1'b0;
            rd_q     <= '0;
            hi_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StWrHi) begin
                hi_q <= result_q[2*DATA_W-1:DATA_W];
            end
            // Outputs of the write in progress are already driven, so overwriting is safe.
            if (accept) begin
                result_q <= in_result;
                wide_q   <= in_wide;
                rd_q     <= in_rd;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback.
module tb_alu_writeback;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic        in_wide;
    logic [4:0]  in_rd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] hi_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_writeback #(.DATA_W(32), .RADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_result(in_result),
        .in_wide  (in_wide),
        .in_rd    (in_rd),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .hi_out   (hi_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [63:0] res, input logic wide);
        in_valid  = 1'b1;
        in_rd     = rd;
        in_result = res;
        in_wide   = wide;
    endtask

    task automatic idle_in();
        in_valid  = 1'b0;
        in_rd     = '0;
        in_result = '0;
        in_wide   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        step();
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== 38'd0) begin
            errors++;
            $display("FAIL reset_wr got we=%b a=%0d d=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if ({busy, in_ready, hi_out} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b rdy=%b hi=%h want 0/0/0", busy, in_ready, hi_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_narrow();
        offer(5'd5, 64'h0000_0000_0000_00B5, 1'b0);
        step();
        idle_in();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hB5}) begin
            errors++;
            $display("FAIL narrow_wr got we=%b a=%0d d=%h want 1/5/b5", rf_we, rf_waddr, rf_wdata);
        end
        step();
        checks++;
        if ({busy, rf_we, rf_waddr, rf_wdata} !== 39'd0) begin
            errors++;
            $display("FAIL narrow_idle got busy=%b we=%b a=%0d d=%h want 0", busy, rf_we, rf_waddr,
                     rf_wdata);
        end
    endtask

    task automatic test_wide();
        offer(5'd7, 64'hFFFF_FFFE_0000_0001, 1'b1);
        step();
        idle_in();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, in_ready} !== {1'b1, 5'd7, 32'h1, 1'b0}) begin
            errors++;
            $display("FAIL wide_lo got we=%b a=%0d d=%h rdy=%b want 1/7/1/0", rf_we, rf_waddr,
                     rf_wdata, in_ready);
        end
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, in_ready} !== {1'b1, 5'd8, 32'hFFFF_FFFE, 1'b1}) begin
            errors++;
            $display("FAIL wide_hi got we=%b a=%0d d=%h rdy=%b want 1/8/fffffffe/1", rf_we,
                     rf_waddr, rf_wdata, in_ready);
        end
        step();
        checks++;
        if ({hi_out, busy} !== {32'hFFFF_FFFE, 1'b0}) begin
            errors++;
            $display("FAIL wide_hi_out got hi=%h busy=%b want fffffffe/0", hi_out, busy);
        end
    endtask

    task automatic test_back_to_back();
        offer(5'd1, 64'h11, 1'b0);
        step();
        offer(5'd2, 64'h22, 1'b0);
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, in_ready} !== {1'b1, 5'd1, 32'h11, 1'b1}) begin
            errors++;
            $display("FAIL b2b_1 got we=%b a=%0d d=%h rdy=%b want 1/1/11/1", rf_we, rf_waddr,
                     rf_wdata, in_ready);
        end
        step();
        offer(5'd3, 64'h33, 1'b0);
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd2, 32'h22}) begin
            errors++;
            $display("FAIL b2b_2 got we=%b a=%0d d=%h want 1/2/22", rf_we, rf_waddr, rf_wdata);
        end
        step();
        idle_in();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h33}) begin
            errors++;
            $display("FAIL b2b_3 got we=%b a=%0d d=%h want 1/3/33", rf_we, rf_waddr, rf_wdata);
        end
        step();
        checks++;
        if ({busy, rf_we} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end got busy=%b we=%b want 0/0", busy, rf_we);
        end
        // Wide op followed by a narrow accept during the WR_HI cycle.
        offer(5'd10, 64'h1357_2468_ABCD_0001, 1'b1);
        step();
        idle_in();
        step();
        offer(5'd12, 64'h77, 1'b0);
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, in_ready} !== {1'b1, 5'd11, 32'h1357_2468, 1'b1}) begin
            errors++;
            $display("FAIL hi_overlap got we=%b a=%0d d=%h rdy=%b want 1/11/13572468/1", rf_we,
                     rf_waddr, rf_wdata, in_ready);
        end
        step();
        idle_in();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, hi_out} !== {1'b1, 5'd12, 32'h77, 32'h1357_2468}) begin
            errors++;
            $display("FAIL after_overlap got we=%b a=%0d d=%h hi=%h want 1/12/77/13572468", rf_we,
                     rf_waddr, rf_wdata, hi_out);
        end
        step();
    endtask

    task automatic test_x0_wrap();
        offer(5'd0, 64'h55, 1'b0);
        step();
        idle_in();
        checks++;
        if ({rf_we, rf_waddr, busy} !== {1'b0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL x0_narrow got we=%b a=%0d busy=%b want 0/0/1", rf_we, rf_waddr, busy);
        end
        step();
        offer(5'd31, 64'hAAAA_0000_0000_1234, 1'b1);
        step();
        idle_in();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd31, 32'h1234}) begin
            errors++;
            $display("FAIL wrap_lo got we=%b a=%0d d=%h want 1/31/1234", rf_we, rf_waddr, rf_wdata);
        end
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'hAAAA_0000}) begin
            errors++;
            $display("FAIL wrap_hi got we=%b a=%0d d=%h want 0/0/aaaa0000", rf_we, rf_waddr,
                     rf_wdata);
        end
        step();
        checks++;
        if (hi_out !== 32'hAAAA_0000) begin
            errors++;
            $display("FAIL wrap_hi_out got %h want aaaa0000", hi_out);
        end
    endtask

    task automatic test_reset_mid_op();
        offer(5'd4, 64'h9999_8888_0000_0042, 1'b1);
        step();
        idle_in();
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready got %b want 0", in_ready);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({rf_we, busy, in_ready, hi_out} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL rst_mid got we=%b busy=%b rdy=%b hi=%h want 0/0/1/0", rf_we, busy,
                     in_ready, hi_out);
        end
        step();
        checks++;
        if ({rf_we, busy, hi_out} !== 34'd0) begin
            errors++;
            $display("FAIL rst_after got we=%b busy=%b hi=%h want 0/0/0", rf_we, busy, hi_out);
        end
    endtask

    initial begin
        test_reset();
        test_narrow();
        test_wide();
        test_back_to_back();
        test_x0_wrap();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
